ap_ctrl_profiler: RTL and testbench

// - Synthesisable, multi-channel successor to the simulation-only dataflow monitor.
// - Observes the ap_ctrl handshake of NUM_CH HLS modules or pipelined loops, and measures
//   per channel: transaction count, latency (last/min/max), start interval, stall and busy cycles.
// - Tracks up to MAX_OUTST overlapping transactions per channel (ap_ctrl_chain / pipelined DUTs)

---
 rtl/ap_prof_pkg.sv | 37 +++
 rtl/ap_prof_chan.sv | 137 +++++++++++++
 rtl/ap_ctrl_profiler.sv | 77 +++++++
 tb/tb_ap_ctrl_profiler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_prof_pkg.sv
// rtl/ap_prof_pkg.sv - shared types and constants for the ap_ctrl profiler
package ap_prof_pkg;

    // Register select codes on the read port
    typedef enum logic [2:0] {
        SEL_TXN_START = 3'd0,
        SEL_TXN_DONE  = 3'd1,
        SEL_LAT_LAST  = 3'd2,
        SEL_LAT_MIN   = 3'd3,
        SEL_LAT_MAX   = 3'd4,
        SEL_II_LAST   = 3'd5,
        SEL_STALL_CNT = 3'd6,
        SEL_STATUS    = 3'd7
    } prof_sel_e;

    // STATUS layout: occupancy in the LSBs, then OVF, then UNF directly above it
    localparam int STAT_OCC_LSB = 0;
    localparam int STAT_OVF_OFS = 0;
    localparam int STAT_UNF_OFS = 1;

    // Bits needed to hold an occupancy of 0..max_outst
    function automatic int occ_width(input int max_outst);
        int w;
        w = 1;
        while ((1 << w) < (max_outst + 1)) w++;
        return w;
    endfunction

    // Bits needed to address max_outst FIFO slots (at least one)
    function automatic int ptr_width(input int max_outst);
        int w;
        w = 1;
        while ((1 << w) < max_outst) w++;
        return w;
    endfunction

endpackage

// File: rtl/ap_prof_chan.sv
// rtl/ap_prof_chan.sv - one monitored channel: start timestamp FIFO and statistics
module ap_prof_chan
    import ap_prof_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_ready,
    input  logic                   i_done,
    input  logic                   i_continue,
    input  logic                   i_enable,
    input  logic                   i_clear,
    input  logic [CNT_W-1:0]       i_ts,
    output logic [7:0][CNT_W-1:0]  o_regs,
    output logic [CNT_W-1:0]       o_busy_cnt
);

    localparam int OW = occ_width(MAX_OUTST);
    localparam int PW = ptr_width(MAX_OUTST);

    logic [CNT_W-1:0] r_mem [MAX_OUTST];
    logic [PW-1:0]    r_rd_ptr, r_wr_ptr;
    logic [OW-1:0]    r_occ;
    logic             r_ovf, r_unf, r_have_prev;
    logic [CNT_W-1:0] r_prev_ts, r_txn_start, r_txn_done, r_lat_last, r_lat_min;
    logic [CNT_W-1:0] r_lat_max, r_ii_last, r_stall_cnt, r_busy_cnt;

    logic             w_push, w_pop, w_stall, w_empty, w_full;
    logic             w_bypass, w_do_push, w_do_pop, w_lat_vld;
    logic [CNT_W-1:0] w_lat, w_status;
    logic [PW-1:0]    w_rd_ptr_nxt, w_wr_ptr_nxt;

    assign w_push    = i_start & i_ready;
    assign w_pop     = i_done & i_continue;
    assign w_stall   = i_done & ~i_continue;
    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == OW'(MAX_OUTST));
    // A start and finish in the same cycle on an empty FIFO never touch storage
    assign w_bypass  = w_push & w_pop & w_empty;
    assign w_do_pop  = w_pop & ~w_empty;
    // A full FIFO can still accept a start when the head leaves in the same cycle
    assign w_do_push = w_push & ~w_bypass & (~w_full | w_pop);
    assign w_lat_vld = w_bypass | w_do_pop;
    assign w_lat     = w_bypass ? '0 : (i_ts - r_mem[r_rd_ptr]);

    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(MAX_OUTST - 1)) ? '0 : r_rd_ptr + PW'(1);
    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(MAX_OUTST - 1)) ? '0 : r_wr_ptr + PW'(1);

    // Timestamp storage; contents are meaningless while the slot is not occupied
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_ts;
    end

    // FIFO bookkeeping, sticky flags and gated statistics
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_occ       <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_have_prev <= 1'b0;
            r_prev_ts   <= '0;
            r_txn_start <= '0;
            r_txn_done  <= '0;
            r_lat_last  <= '0;
            r_lat_min   <= '1;
            r_lat_max   <= '0;
            r_ii_last   <= '0;
            r_stall_cnt <= '0;
            r_busy_cnt  <= '0;
        end else if (i_clear) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_occ       <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_have_prev <= 1'b0;
            r_prev_ts   <= '0;
            r_txn_start <= '0;
            r_txn_done  <= '0;
            r_lat_last  <= '0;
            r_lat_min   <= '1;
            r_lat_max   <= '0;
            r_ii_last   <= '0;
            r_stall_cnt <= '0;
            r_busy_cnt  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_do_pop)  r_rd_ptr <= w_rd_ptr_nxt;
            r_occ <= r_occ + OW'(w_do_push) - OW'(w_do_pop);
            if (w_push & ~w_pop & w_full)  r_ovf <= 1'b1;
            if (w_pop & ~w_push & w_empty) r_unf <= 1'b1;
            // Start spacing is tracked even while frozen so II stays meaningful on resume
            if (w_push) begin
                r_prev_ts   <= i_ts;
                r_have_prev <= 1'b1;
            end
            if (i_enable) begin
                if (w_push) begin
                    if (~&r_txn_start) r_txn_start <= r_txn_start + CNT_W'(1);
                    if (r_have_prev)   r_ii_last   <= i_ts - r_prev_ts;
                end
                if (w_pop && (~&r_txn_done)) r_txn_done <= r_txn_done + CNT_W'(1);
                if (w_lat_vld) begin
                    r_lat_last <= w_lat;
                    if (w_lat < r_lat_min) r_lat_min <= w_lat;
                    if (w_lat > r_lat_max) r_lat_max <= w_lat;
                end
                if (w_stall && (~&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                if (!w_empty && (~&r_busy_cnt)) r_busy_cnt <= r_busy_cnt + CNT_W'(1);
            end
        end
    end

    // STATUS word assembly
    always_comb begin
        w_status = '0;
        w_status[STAT_OCC_LSB +: OW]   = r_occ;
        w_status[OW + STAT_OVF_OFS]    = r_ovf;
        w_status[OW + STAT_UNF_OFS]    = r_unf;
    end

    assign o_regs[SEL_TXN_START] = r_txn_start;
    assign o_regs[SEL_TXN_DONE]  = r_txn_done;
    assign o_regs[SEL_LAT_LAST]  = r_lat_last;
    assign o_regs[SEL_LAT_MIN]   = r_lat_min;
    assign o_regs[SEL_LAT_MAX]   = r_lat_max;
    assign o_regs[SEL_II_LAST]   = r_ii_last;
    assign o_regs[SEL_STALL_CNT] = r_stall_cnt;
    assign o_regs[SEL_STATUS]    = w_status;
    assign o_busy_cnt            = r_busy_cnt;

endmodule

// File: rtl/ap_ctrl_profiler.sv
// rtl/ap_ctrl_profiler.sv - multi-channel ap_ctrl handshake profiler with registered read port
module ap_ctrl_profiler
    import ap_prof_pkg::*;
#(
    parameter int  NUM_CH    = 4,
    parameter int  CNT_W     = 32,
    parameter int  MAX_OUTST = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          i_ap_clk,
    input  logic                          i_ap_rst_n,
    input  logic [NUM_CH-1:0]             i_ap_start,
    input  logic [NUM_CH-1:0]             i_ap_ready,
    input  logic [NUM_CH-1:0]             i_ap_done,
    input  logic [NUM_CH-1:0]             i_ap_continue,
    input  logic                          i_enable,
    input  logic                          i_clear,
    input  logic                          i_rd_en,
    input  logic [CH_W-1:0]               i_rd_ch,
    input  logic [2:0]                    i_rd_sel,
    output logic [CNT_W-1:0]              o_rd_data,
    output logic                          o_rd_valid,
    output logic [NUM_CH-1:0][CNT_W-1:0]  o_busy_cnt
);

    logic [CNT_W-1:0]       r_ts;
    logic [CNT_W-1:0]       r_rd_data;
    logic                   r_rd_valid;
    logic [7:0][CNT_W-1:0]  w_regs [NUM_CH];
    logic [CNT_W-1:0]       w_rd_mux;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ap_prof_chan #(
            .CNT_W     (CNT_W),
            .MAX_OUTST (MAX_OUTST)
        ) u_chan (
            .i_clk      (i_ap_clk),
            .i_rst_n    (i_ap_rst_n),
            .i_start    (i_ap_start[g]),
            .i_ready    (i_ap_ready[g]),
            .i_done     (i_ap_done[g]),
            .i_continue (i_ap_continue[g]),
            .i_enable   (i_enable),
            .i_clear    (i_clear),
            .i_ts       (r_ts),
            .o_regs     (w_regs[g]),
            .o_busy_cnt (o_busy_cnt[g])
        );
    end

    // Free-running timestamp; wraps and is untouched by clear
    always_ff @(posedge i_ap_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) r_ts <= '0;
        else             r_ts <= r_ts + CNT_W'(1);
    end

    // Read select; out-of-range channels read as zero
    always_comb begin
        w_rd_mux = '0;
        if (int'(i_rd_ch) < NUM_CH) w_rd_mux = w_regs[i_rd_ch][prof_sel_e'(i_rd_sel)];
    end

    // Read register: data held between strobes
    always_ff @(posedge i_ap_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) r_rd_data <= w_rd_mux;
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_ap_ctrl_profiler.sv
// tb/tb_ap_ctrl_profiler.sv - scoreboard bench for ap_ctrl_profiler with a queue-based reference model
module tb_ap_ctrl_profiler;

    localparam int NCH  = 3;
    localparam int W    = 8;
    localparam int MO   = 4;
    localparam int MASK = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic [NCH-1:0]         start, ready, done, cont;
    logic                   enable, clear, rd_en;
    logic [1:0]             rd_ch;
    logic [2:0]             rd_sel;
    logic [W-1:0]           rd_data;
    logic                   rd_valid;
    logic [NCH-1:0][W-1:0]  busy;

    ap_ctrl_profiler #(.NUM_CH(NCH), .CNT_W(W), .MAX_OUTST(MO)) u_dut (
        .i_ap_clk(clk), .i_ap_rst_n(rst_n), .i_ap_start(start), .i_ap_ready(ready),
        .i_ap_done(done), .i_ap_continue(cont), .i_enable(enable), .i_clear(clear),
        .i_rd_en(rd_en), .i_rd_ch(rd_ch), .i_rd_sel(rd_sel), .o_rd_data(rd_data),
        .o_rd_valid(rd_valid), .o_busy_cnt(busy)
    );

    typedef struct { int tag; int ch; int sel; int val; } rd_exp_t;
    typedef struct { int tag; logic [NCH-1:0][W-1:0] b; } busy_exp_t;
    rd_exp_t   rdq[$];
    busy_exp_t bq[$];

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;
    int rd_force = -1;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference model: per-channel queue of start timestamps plus plain counters
    int m_q[NCH][$];
    int m_txs[NCH], m_txd[NCH], m_llast[NCH], m_lmin[NCH], m_lmax[NCH];
    int m_ii[NCH], m_stall[NCH], m_busy[NCH], m_prev[NCH];
    bit m_ovf[NCH], m_unf[NCH], m_hprev[NCH];
    int ts_m;

    function automatic int sat(input int x);
        return (x >= MASK) ? MASK : x + 1;
    endfunction

    task automatic m_clear(input int c);
        m_q[c].delete();
        m_txs[c] = 0; m_txd[c] = 0; m_llast[c] = 0; m_lmin[c] = MASK; m_lmax[c] = 0;
        m_ii[c] = 0; m_stall[c] = 0; m_busy[c] = 0; m_prev[c] = 0;
        m_ovf[c] = 0; m_unf[c] = 0; m_hprev[c] = 0;
    endtask

    function automatic int m_reg(input int c, input int sel);
        if (c >= NCH) return 0;
        case (sel)
            0: return m_txs[c];
            1: return m_txd[c];
            2: return m_llast[c];
            3: return m_lmin[c];
            4: return m_lmax[c];
            5: return m_ii[c];
            6: return m_stall[c];
            default: return (int'(m_unf[c]) << 4) | (int'(m_ovf[c]) << 3) | m_q[c].size();
        endcase
    endfunction

    // One clock edge of the reference behaviour, using the currently driven inputs
    task automatic m_edge();
        if (clear) begin
            for (int c = 0; c < NCH; c++) m_clear(c);
        end else begin
            for (int c = 0; c < NCH; c++) begin
                bit push, pop, stl, byp, lat_v;
                int lat, occ0;
                push = start[c] & ready[c];
                pop  = done[c] & cont[c];
                stl  = done[c] & ~cont[c];
                occ0 = m_q[c].size();
                byp  = push && pop && (occ0 == 0);
                lat_v = 0;
                lat   = 0;
                if (pop) begin
                    if (occ0 > 0) begin
                        lat = (ts_m - m_q[c].pop_front()) & MASK;
                        lat_v = 1;
                    end else if (push) lat_v = 1;
                    else m_unf[c] = 1;
                end
                if (push && !byp) begin
                    if (m_q[c].size() < MO) m_q[c].push_back(ts_m);
                    else m_ovf[c] = 1;
                end
                if (enable) begin
                    if (push) begin
                        m_txs[c] = sat(m_txs[c]);
                        if (m_hprev[c]) m_ii[c] = (ts_m - m_prev[c]) & MASK;
                    end
                    if (pop) m_txd[c] = sat(m_txd[c]);
                    if (lat_v) begin
                        m_llast[c] = lat;
                        if (lat < m_lmin[c]) m_lmin[c] = lat;
                        if (lat > m_lmax[c]) m_lmax[c] = lat;
                    end
                    if (stl) m_stall[c] = sat(m_stall[c]);
                    if (occ0 > 0) m_busy[c] = sat(m_busy[c]);
                end
                if (push) begin
                    m_prev[c]  = ts_m;
                    m_hprev[c] = 1;
                end
            end
        end
        ts_m = (ts_m + 1) & MASK;
    endtask

    // Issue the driven inputs for one edge and queue what the DUT must show afterwards
    task automatic step();
        busy_exp_t be;
        if (rd_en) begin
            rd_exp_t e;
            e.tag = edge_n + 1;
            e.ch  = int'(rd_ch);
            e.sel = int'(rd_sel);
            e.val = (rd_force >= 0) ? rd_force : m_reg(int'(rd_ch), int'(rd_sel));
            rdq.push_back(e);
        end
        m_edge();
        be.tag = edge_n + 1;
        for (int c = 0; c < NCH; c++) be.b[c] = W'(m_busy[c]);
        bq.push_back(be);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = '0; ready = '0; done = '0; cont = '1;
        rd_en = 1'b0; clear = 1'b0;
    endtask

    task automatic read_chk(input int ch, input int sel, input int val);
        idle_inputs();
        rd_en = 1'b1; rd_ch = 2'(ch); rd_sel = 3'(sel); rd_force = val;
        step();
        rd_en = 1'b0; rd_force = -1;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic wait_ts(input int t);
        idle_inputs();
        while (ts_m != t) step();
    endtask

    task automatic pulse(input int ch, input bit p, input bit d, input bit c);
        idle_inputs();
        start[ch] = p; ready[ch] = p; done[ch] = d; cont[ch] = c;
        step();
        idle_inputs();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        idle_inputs();
        enable = 1'b1;
        rdq.delete();
        bq.delete();
        for (int c = 0; c < NCH; c++) m_clear(c);
        ts_m = 0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations
    always @(negedge clk) begin : mon
        rd_exp_t   e;
        busy_exp_t b;
        if (!rst_n) begin
            check("reset rd_valid", 32'(rd_valid), 0);
            check("reset rd_data", 32'(rd_data), 0);
            check("reset busy_cnt", 32'(busy), 0);
        end else begin
            if (rd_valid) begin
                if (rdq.size() == 0 || rdq[0].tag != edge_n) begin
                    check("rd_valid unexpected", 32'(rd_valid), 0);
                end else begin
                    e = rdq.pop_front();
                    check($sformatf("rd ch%0d sel%0d", e.ch, e.sel), 32'(rd_data), e.val);
                end
            end else if (rdq.size() != 0 && rdq[0].tag <= edge_n) begin
                e = rdq.pop_front();
                check($sformatf("rd_valid missing ch%0d sel%0d", e.ch, e.sel), 32'(rd_valid), 1);
            end
            if (bq.size() != 0 && bq[0].tag == edge_n) begin
                b = bq.pop_front();
                check("busy_cnt", 32'(busy), 32'(b.b));
            end
        end
    end

    initial begin
        rd_ch = '0; rd_sel = '0; enable = 1'b1;
        do_reset(3);

        // Reset state
        read_chk(0, 0, 0);
        read_chk(1, 3, MASK);
        read_chk(2, 7, 0);

        // Single transaction on ch0: push at 10, pop at 17
        wait_ts(10); pulse(0, 1, 0, 1);
        wait_ts(17); pulse(0, 0, 1, 1);
        read_chk(0, 2, 7); read_chk(0, 3, 7); read_chk(0, 4, 7); read_chk(0, 1, 1);

        // Pipelined ch1: pushes 5,6,7; pops 12,14,15
        do_clear();
        wait_ts(5); pulse(1, 1, 0, 1); pulse(1, 1, 0, 1); pulse(1, 1, 0, 1);
        wait_ts(12); pulse(1, 0, 1, 1);
        wait_ts(14); pulse(1, 0, 1, 1); pulse(1, 0, 1, 1);
        read_chk(1, 4, 8); read_chk(1, 3, 7); read_chk(1, 5, 1); read_chk(1, 7, 0); read_chk(1, 1, 3);

        // Overflow: 5 pushes into a 4-deep FIFO, then clear
        do_clear();
        repeat (5) pulse(0, 1, 0, 1);
        read_chk(0, 7, 12); read_chk(0, 0, 5);
        do_clear();
        read_chk(0, 0, 0); read_chk(0, 3, MASK); read_chk(0, 7, 0);

        // Stall on ch2, then underflow
        wait_ts(40); pulse(2, 1, 0, 1);
        repeat (3) pulse(2, 0, 1, 0);
        pulse(2, 0, 1, 1);
        read_chk(2, 6, 3); read_chk(2, 2, 4); read_chk(2, 1, 1);
        pulse(2, 0, 1, 1);
        read_chk(2, 7, 16); read_chk(2, 1, 2); read_chk(2, 2, 4);

        // Bypass on empty FIFO, then frozen statistics
        do_clear();
        pulse(0, 1, 0, 1); idle_inputs(); step(); step(); pulse(0, 0, 1, 1);
        pulse(0, 1, 1, 1);
        read_chk(0, 2, 0); read_chk(0, 3, 0); read_chk(0, 4, 3); read_chk(0, 7, 0);
        enable = 1'b0;
        pulse(1, 1, 0, 1); pulse(1, 0, 1, 1); pulse(1, 1, 0, 1); pulse(1, 0, 1, 1); pulse(1, 1, 0, 1);
        enable = 1'b1;
        read_chk(1, 1, 0); read_chk(1, 0, 0); read_chk(1, 7, 1);

        // Timestamp wrap and out-of-range channel
        do_clear();
        wait_ts(250); pulse(0, 1, 0, 1);
        wait_ts(4); pulse(0, 0, 1, 1);
        read_chk(0, 2, 10); read_chk(3, 0, 0); read_chk(3, 7, 0);

        // Reset mid-transaction, then a late done
        do_clear();
        pulse(1, 1, 0, 1); idle_inputs(); step();
        do_reset(2);
        pulse(1, 0, 1, 1);
        read_chk(1, 7, 16); read_chk(1, 1, 1); read_chk(1, 2, 0); read_chk(1, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start  = 3'($urandom);
            ready  = 3'($urandom);
            done   = 3'($urandom) & 3'($urandom);
            cont   = 3'($urandom) | 3'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 999) == 0);
            rd_en  = $urandom_range(0, 1) == 1;
            rd_ch  = 2'($urandom);
            rd_sel = 3'($urandom);
            step();
            if (i == 1500) do_reset(2);
        end

        idle_inputs();
        enable = 1'b1;
        repeat (3) step();
        check("read queue drained", 32'(rdq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
